// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter
//
// Sits between the single-cycle core's memory stage and a registered
// req/gnt/rvalid data bus. It turns a zero-latency load/store into a bus
// transaction and stalls the core until that transaction finishes. It also
// steers store bytes onto the right lanes and extracts and extends load data.
// A misaligned access is rejected in the same cycle and never reaches the bus.
// A transaction that takes too long is closed out with an error, so the core
// can never hang.
//
// Parameters
//   DATA_WIDTH      data/address width (only 32 is supported)
//   TIMEOUT_CYCLES  cycles allowed in REQ+WAIT before forcing completion (>= 2)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid_i       core memory access (MemRead | MemWrite), held while stalled
//   we_i              1 = store, 0 = load
//   funct3_i          RV32I width/sign code
//   addr_i            byte address from the ALU
//   wr_data_i         raw rs2 value
//   rd_data_o         extended load result, valid in the DONE cycle
//   stall_o           freezes PC and register writeback
//   misaligned_o      pulse for a rejected misaligned access
//   bus_err_o         pulse in the DONE cycle after a timeout
//   bus_req_o ..      registered bus request, write flag, word address,
//   bus_wdata_o       byte enables and lane-replicated write data
//   bus_gnt_i         request accepted
//   bus_rvalid_i      read data valid
//   bus_rdata_i       read data word

module lsu_bus_adapter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  stall_o,
  output logic                  misaligned_o,
  output logic                  bus_err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [DATA_WIDTH-1:0] bus_addr_o,
  output logic [3:0]            bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [TIMER_W-1:0]    timer;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  is_byte;
  logic                  is_half;
  logic                  misaligned_access;
  logic                  accept;
  logic                  reject;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_ext;

  // Access size decode. Loads and stores give different meanings to the
  // upper funct3 bit. Any code that does not name a byte or halfword access
  // is treated as a full word, so undefined codes behave as LW/SW.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (we_i) begin
      is_byte = (funct3_i == 3'b000);
      is_half = (funct3_i == 3'b001);
    end else begin
      is_byte = (funct3_i == 3'b000) || (funct3_i == 3'b100);
      is_half = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    end
  end

  assign misaligned_access = (is_half && addr_i[0]) ||
                             (!is_byte && !is_half && (addr_i[1:0] != 2'b00));

  assign accept = (state == S_IDLE) && req_valid_i && !misaligned_access;
  assign reject = rst_n && (state == S_IDLE) && req_valid_i && misaligned_access;

  // Store lane steering. The bus sees the value replicated across every lane,
  // and the byte enables pick the lane that is actually written. Loads always
  // fetch the whole word and select the bytes afterwards.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wr_data_i;
    if (we_i) begin
      if (is_byte) begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = {4{wr_data_i[7:0]}};
      end else if (is_half) begin
        be_next    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_next = {2{wr_data_i[15:0]}};
      end
    end
  end

  // Load extraction uses the byte offset and funct3 latched at accept time.
  // This is safe even though the core holds its inputs stable while stalled.
  always_comb begin
    ld_byte = bus_rdata_i[7:0];
    case (off_q)
      2'd0:    ld_byte = bus_rdata_i[7:0];
      2'd1:    ld_byte = bus_rdata_i[15:8];
      2'd2:    ld_byte = bus_rdata_i[23:16];
      default: ld_byte = bus_rdata_i[31:24];
    endcase
    ld_half  = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    load_ext = bus_rdata_i;
    case (funct3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h000000, ld_byte};
      3'b101:  load_ext = {16'h0000, ld_half};
      default: load_ext = bus_rdata_i;
    endcase
  end

  // The stall drops in DONE, when the core commits. It also drops
  // immediately for a rejected misaligned access, so the core moves on
  // without touching the bus.
  assign stall_o      = rst_n && req_valid_i && (state != S_DONE) &&
                        !((state == S_IDLE) && misaligned_access);
  assign misaligned_o = reject;
  assign rd_data_o    = reject ? '0 : rd_data_q;

  // Main controller. The timer only advances in REQ and WAIT. Reaching its
  // last value without completing forces DONE with a zero result and an
  // error pulse. rvalid is only ever sampled in WAIT, so stray responses
  // seen in other states are ignored. This covers responses after a
  // timeout and responses after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      timer       <= '0;
      rd_data_q   <= '0;
      bus_err_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= '0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_REQ;
            funct3_q    <= funct3_i;
            off_q       <= addr_i[1:0];
            timer       <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= we_i;
            bus_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            bus_be_o    <= be_next;
            bus_wdata_o <= wdata_next;
          end
        end
        S_REQ: begin
          if (bus_gnt_i && bus_we_o) begin
            state     <= S_DONE;
            bus_req_o <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            state     <= S_DONE;
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            rd_data_q <= '0;
          end else if (bus_gnt_i) begin
            state     <= S_WAIT;
            bus_req_o <= 1'b0;
            timer     <= timer + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus_rvalid_i) begin
            state     <= S_DONE;
            rd_data_q <= load_ext;
          end else if (timer == TIMER_LAST) begin
            state     <= S_DONE;
            bus_err_o <= 1'b1;
            rd_data_q <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb_lsu_bus_adapter
//
// Directed bench for lsu_bus_adapter. It plays the core and the bus by hand,
// drives each access through its states and compares the outputs against
// hand-computed values. The expected results are worked out in the vector
// calls below.

module tb_lsu_bus_adapter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  lsu_bus_adapter #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .we_i        (we_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wr_data_i   (wr_data_i),
    .rd_data_o   (rd_data_o),
    .stall_o     (stall_o),
    .misaligned_o(misaligned_o),
    .bus_err_o   (bus_err_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_gnt_i   (bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i (bus_rdata_i)
  );

  // Single comparison point: counts the vector and reports a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Core-side request drive.
  task automatic applyStimulus(input logic valid, input logic we,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    req_valid_i = valid;
    we_i        = we;
    funct3_i    = f3;
    addr_i      = addr;
    wr_data_i   = wdata;
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled one more time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete aligned access, with the grant in the first REQ cycle and,
  // for loads, rvalid in the following cycle. Returns just after the edge
  // into IDLE, leaving the caller to present the next request back-to-back.
  task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rd);
    int stall_cycles;
    stall_cycles = 0;
    applyStimulus(1'b1, we, f3, addr, wdata);
    #1;
    if (stall_o) stall_cycles++;
    checkOutput({tag, " idle bus_req"}, 32'(bus_req_o), 32'd0);
    step();
    bus_gnt_i = 1'b1;
    #1;
    if (stall_o) stall_cycles++;
    checkOutput({tag, " req bus_req"}, 32'(bus_req_o), 32'd1);
    checkOutput({tag, " bus_addr"}, bus_addr_o, exp_addr);
    checkOutput({tag, " bus_be"}, 32'(bus_be_o), 32'(exp_be));
    checkOutput({tag, " bus_we"}, 32'(bus_we_o), 32'(we));
    if (we) checkOutput({tag, " bus_wdata"}, bus_wdata_o, exp_wdata);
    step();
    bus_gnt_i = 1'b0;
    if (!we) begin
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = rdata;
      #1;
      if (stall_o) stall_cycles++;
      checkOutput({tag, " wait bus_req"}, 32'(bus_req_o), 32'd0);
      step();
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'h0BAD_0BAD;
    end
    #1;
    checkOutput({tag, " done stall"}, 32'(stall_o), 32'd0);
    if (!we) checkOutput({tag, " rd_data"}, rd_data_o, exp_rd);
    checkOutput({tag, " stall cycles"}, stall_cycles, we ? 32'd2 : 32'd3);
    step();
  endtask

  initial begin
    int req_cycles;
    int cyc;

    rst_n        = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0);
    #2;
    $display("[TB] reset checks");
    checkOutput("reset stall", 32'(stall_o), 32'd0);
    checkOutput("reset misaligned", 32'(misaligned_o), 32'd0);
    checkOutput("reset bus_req", 32'(bus_req_o), 32'd0);
    checkOutput("reset bus_addr", bus_addr_o, 32'h0);
    checkOutput("reset bus_be", 32'(bus_be_o), 32'h0);
    checkOutput("reset rd_data", rd_data_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] aligned accesses");
    run_access("SW",  1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,
               32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    run_access("SB",  1'b1, 3'b000, 32'h0000_0203, 32'h1234_56A5, 32'h0,
               32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    run_access("LB",  1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000,
               32'h0000_0100, 4'b1111, 32'h0, 32'hFFFF_FF80);
    run_access("LBU", 1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000,
               32'h0000_0100, 4'b1111, 32'h0, 32'h0000_0080);
    run_access("LH",  1'b0, 3'b001, 32'h0000_0106, 32'h0, 32'h8001_0000,
               32'h0000_0104, 4'b1111, 32'h0, 32'hFFFF_8001);
    run_access("LHU", 1'b0, 3'b101, 32'h0000_0106, 32'h0, 32'h8001_0000,
               32'h0000_0104, 4'b1111, 32'h0, 32'h0000_8001);
    run_access("SH",  1'b1, 3'b001, 32'h0000_020A, 32'h0000_BEEF, 32'h0,
               32'h0000_0208, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_access("LD110", 1'b0, 3'b110, 32'h0000_0300, 32'h0, 32'h89AB_CDEF,
               32'h0000_0300, 4'b1111, 32'h0, 32'h89AB_CDEF);
    run_access("ST100", 1'b1, 3'b100, 32'h0000_0304, 32'h0102_0304, 32'h0,
               32'h0000_0304, 4'b1111, 32'h0102_0304, 32'h0);
    run_access("LB3", 1'b0, 3'b000, 32'h0000_0303, 32'h0, 32'h7F00_0000,
               32'h0000_0300, 4'b1111, 32'h0, 32'h0000_007F);

    $display("[TB] misaligned accesses");
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0);
    #1;
    checkOutput("LH mis pulse", 32'(misaligned_o), 32'd1);
    checkOutput("LH mis stall", 32'(stall_o), 32'd0);
    checkOutput("LH mis rd_data", rd_data_o, 32'h0);
    checkOutput("LH mis bus_req", 32'(bus_req_o), 32'd0);
    step();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0102, 32'h5555_5555);
    #1;
    checkOutput("SW mis pulse", 32'(misaligned_o), 32'd1);
    checkOutput("SW mis stall", 32'(stall_o), 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("mis pulse ends", 32'(misaligned_o), 32'd0);
    checkOutput("mis no bus_req", 32'(bus_req_o), 32'd0);
    step();

    $display("[TB] reset mid-transaction");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
    step();
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    #1;
    checkOutput("wait stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("rst bus_req", 32'(bus_req_o), 32'd0);
    checkOutput("rst bus_addr", bus_addr_o, 32'h0);
    checkOutput("rst rd_data", rd_data_o, 32'h0);
    step();
    step();
    rst_n        = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFE_F00D;
    step();
    step();
    bus_rvalid_i = 1'b0;
    #1;
    checkOutput("late rvalid rd_data", rd_data_o, 32'h0);
    checkOutput("post rst bus_we", 32'(bus_we_o), 32'd0);
    checkOutput("post rst bus_be", 32'(bus_be_o), 32'h0);
    checkOutput("post rst stall", 32'(stall_o), 32'd0);
    step();
    run_access("LW", 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h1122_3344,
               32'h0000_0500, 4'b1111, 32'h0, 32'h1122_3344);

    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0);
    step();
    #1;
    req_cycles = 0;
    cyc        = 0;
    while (bus_err_o !== 1'b1 && cyc < 4 * TIMEOUT) begin
      if (bus_req_o) req_cycles++;
      cyc++;
      step();
      #1;
    end
    checkOutput("timeout err", 32'(bus_err_o), 32'd1);
    checkOutput("timeout req cycles", req_cycles, TIMEOUT);
    checkOutput("timeout bus_req", 32'(bus_req_o), 32'd0);
    checkOutput("timeout stall", 32'(stall_o), 32'd0);
    checkOutput("timeout rd_data", rd_data_o, 32'h0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD_BEEF;
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("err pulse ends", 32'(bus_err_o), 32'd0);
    step();
    bus_rvalid_i = 1'b0;
    #1;
    checkOutput("post timeout rd_data", rd_data_o, 32'h0);
    checkOutput("post timeout bus_req", 32'(bus_req_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
